// File: rtl/seq_div_if.sv
// ============================================================================
// Module   : seq_div_if
// Brief    : Start/done handshake and result bundle for the seq_div divider.
//            master = requester side, slave = divider side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_div_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, ovf
  );
endinterface

`default_nettype wire

// File: rtl/seq_div.sv
// ============================================================================
// Module   : seq_div
// Brief    : Multi-cycle restoring divider, one quotient bit per clock, MSB
//            first. Start/done handshake through seq_div_if.
//            Optional macro SEQ_DIV_SIGNED_EN selects two's-complement
//            operands (magnitude division plus sign fix-up on completion).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  seq_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] q_q,      q_d;       // dividend shift register / quotient bits
  logic [WIDTH-1:0] d_q,      d_d;       // latched divisor
  // The partial remainder is always below the divisor between steps, so its
  // top bit is known zero and only WIDTH bits need storing.
  logic [WIDTH-1:0] r_q,      r_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] quot_q,   quot_d;
  logic [WIDTH-1:0] rem_q,    rem_d;
  logic             dz_q,     dz_d;

`ifdef SEQ_DIV_SIGNED_EN
  logic             dvd_neg_q, dvd_neg_d;  // dividend was negative
  logic             quo_neg_q, quo_neg_d;  // operand signs differed
  logic             ovf_pend_q, ovf_pend_d;// most-negative / -1 detected
  logic             ovf_q,    ovf_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction
`endif

  logic             accept;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;

  assign accept  = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign r_shift = {r_q, q_q[WIDTH-1]};
  assign trial   = r_shift - {1'b0, d_q};

  // Next-state logic: one restoring step per CALC cycle, operand load on accept.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef SEQ_DIV_SIGNED_EN
    dvd_neg_d  = dvd_neg_q;
    quo_neg_d  = quo_neg_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
`endif

    case (state_q)
      CALC: begin
        // Keep the shifted value when the trial subtraction borrows.
        r_d     = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        q_d     = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
`ifdef SEQ_DIV_SIGNED_EN
          quot_d = quo_neg_q ? -q_d : q_d;
          rem_d  = dvd_neg_q ? -r_d : r_d;
          ovf_d  = ovf_pend_q;
`else
          quot_d = q_d;
          rem_d  = r_d;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new request overrides the DONE->IDLE return so back-to-back works.
    if (accept) begin
      r_d     = '0;
      count_d = '0;
      dz_d    = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      q_d        = mag(bus.dividend);
      d_d        = mag(bus.divisor);
      dvd_neg_d  = bus.dividend[WIDTH-1];
      quo_neg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      ovf_pend_d = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (bus.divisor == '1);
      ovf_d      = 1'b0;
`else
      q_d     = bus.dividend;
      d_d     = bus.divisor;
`endif
      if (bus.divisor == '0) begin
        // Division by zero completes immediately with fixed results.
        state_d = DONE;
        quot_d  = '1;
        rem_d   = bus.dividend;
        dz_d    = 1'b1;
      end else begin
        state_d = CALC;
      end
    end

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      dvd_neg_q  <= 1'b0;
      quo_neg_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef SEQ_DIV_SIGNED_EN
      dvd_neg_q  <= dvd_neg_d;
      quo_neg_q  <= quo_neg_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
`ifdef SEQ_DIV_SIGNED_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule

`default_nettype wire
